// File: rtl/sender_pkg.sv
// Shared definitions for the serial frame sender and its future receiver path.
package sender_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic START_BIT = 1'b1;

    // Total bit periods one word occupies on the line, gap included.
    function automatic int frame_bits(input int data_w, input int gap_bits);
        return 32'sd1 + data_w + gap_bits;
    endfunction

endpackage

// File: rtl/sender_fifo.sv
// Synchronous FIFO without fall-through: a pushed word is visible to pop
// only from the following cycle, because empty/full come from the registered level.
module sender_fifo #(
    parameter int DATA_W     = 40,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  push,
    input  logic [DATA_W-1:0]                     wr_data,
    input  logic                                  pop,
    output logic [DATA_W-1:0]                     rd_data,
    output logic                                  full,
    output logic                                  empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH+1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              do_push_s;
    logic              do_pop_s;

    assign full      = (level_q == LVL_FULL);
    assign empty     = (level_q == LVL_W'(0));
    assign level     = level_q;
    assign rd_data   = mem_q[rd_ptr_q];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            level_q  <= LVL_W'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/serial_frame_sender.sv
// Buffers parallel words and sends each as start bit + DATA_W data bits + GAP_BITS idle
// bit-times, advancing only on the external bit_tick strobe.
module serial_frame_sender
    import sender_pkg::*;
#(
    parameter int DATA_W     = 40,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_BITS   = 1,
    parameter int IDLE_LEVEL = 0,
    parameter int MSB_FIRST  = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [DATA_W-1:0]                     in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  bit_tick,
    output logic                                  sout,
    output logic                                  busy,
    output logic                                  frame_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       level
);

    localparam int BIT_W = $clog2(DATA_W+1);
    localparam int GAP_W = (GAP_BITS > 0) ? $clog2(GAP_BITS+1) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic             IDLE_BIT = (IDLE_LEVEL != 0) ? 1'b1 : 1'b0;

    state_e            state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              sout_q, sout_d;
    logic              done_q, done_d;
    logic              start_s;
    logic              pop_s;
    logic              push_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [DATA_W-1:0] fifo_data_s;
    logic              next_bit_s;
    logic [DATA_W-1:0] shifted_s;

    sender_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .wr_data (in_data),
        .pop     (pop_s),
        .rd_data (fifo_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (level)
    );

    assign in_ready   = !fifo_full_s && !reset;
    assign push_s     = in_valid && in_ready;
    assign busy       = (state_q != IDLE) || !fifo_empty_s;
    assign sout       = sout_q;
    assign frame_done = done_q;
    assign next_bit_s = (MSB_FIRST != 0) ? shift_q[DATA_W-1] : shift_q[0];
    assign shifted_s  = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);

    // Next-state logic; the end of a gap or a gapless frame falls through to the idle start path.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shift_d   = shift_q;
        sout_d    = sout_q;
        done_d    = 1'b0;
        pop_s     = 1'b0;
        start_s   = 1'b0;
        if (bit_tick) begin
            case (state_q)
                IDLE: start_s = 1'b1;
                SEND: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        done_d = 1'b1;
                        if (GAP_BITS > 0) begin
                            sout_d    = IDLE_BIT;
                            gap_cnt_d = GAP_ONE;
                            state_d   = GAP;
                        end else begin
                            start_s = 1'b1;
                        end
                    end else begin
                        sout_d    = next_bit_s;
                        shift_d   = shifted_s;
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end
                GAP: begin
                    sout_d = IDLE_BIT;
                    if (gap_cnt_q == GAP_LAST) begin
                        start_s = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (start_s) begin
                if (!fifo_empty_s) begin
                    pop_s     = 1'b1;
                    shift_d   = fifo_data_s;
                    sout_d    = START_BIT;
                    bit_cnt_d = BIT_W'(0);
                    state_d   = SEND;
                end else begin
                    sout_d  = IDLE_BIT;
                    state_d = IDLE;
                end
            end else begin
                pop_s = 1'b0;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Serializer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= BIT_W'(0);
            gap_cnt_q <= GAP_W'(0);
            shift_q   <= {DATA_W{1'b0}};
            sout_q    <= IDLE_BIT;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            shift_q   <= shift_d;
            sout_q    <= sout_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_serial_frame_sender.sv
// Directed bench for serial_frame_sender using three differently parametrised instances.
module tb_serial_frame_sender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int fails = 0;

    // Default instance: DATA_W=40, GAP_BITS=1, IDLE_LEVEL=0, MSB first
    logic        def_reset = 1'b1;
    logic [39:0] def_data = 40'h0;
    logic        def_valid = 1'b0;
    logic        def_ready;
    logic        def_tick = 1'b0;
    logic        def_sout;
    logic        def_busy;
    logic        def_done;
    logic [2:0]  def_level;

    // Back-to-back instance: DATA_W=8, GAP_BITS=0
    logic        b_reset = 1'b1;
    logic [7:0]  b_data = 8'h0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic        b_tick = 1'b0;
    logic        b_sout;
    logic        b_busy;
    logic        b_done;
    logic [2:0]  b_level;

    // LSB-first instance with idle-high line: DATA_W=8, GAP_BITS=1
    logic        l_reset = 1'b1;
    logic [7:0]  l_data = 8'h0;
    logic        l_valid = 1'b0;
    logic        l_ready;
    logic        l_tick = 1'b0;
    logic        l_sout;
    logic        l_busy;
    logic        l_done;
    logic [2:0]  l_level;

    serial_frame_sender u_def (
        .clk(clk), .reset(def_reset), .in_data(def_data), .in_valid(def_valid),
        .in_ready(def_ready), .bit_tick(def_tick), .sout(def_sout), .busy(def_busy),
        .frame_done(def_done), .level(def_level)
    );

    serial_frame_sender #(.DATA_W(8), .GAP_BITS(0)) u_b2b (
        .clk(clk), .reset(b_reset), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .bit_tick(b_tick), .sout(b_sout), .busy(b_busy),
        .frame_done(b_done), .level(b_level)
    );

    serial_frame_sender #(.DATA_W(8), .MSB_FIRST(0), .IDLE_LEVEL(1)) u_lsb (
        .clk(clk), .reset(l_reset), .in_data(l_data), .in_valid(l_valid),
        .in_ready(l_ready), .bit_tick(l_tick), .sout(l_sout), .busy(l_busy),
        .frame_done(l_done), .level(l_level)
    );

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++; if (def_ready !== 1'b0) begin fails++; $display("FAIL rst_ready_def: got %b want 0", def_ready); end
        tests_run++; if (b_ready !== 1'b0) begin fails++; $display("FAIL rst_ready_b2b: got %b want 0", b_ready); end
        tests_run++; if (l_ready !== 1'b0) begin fails++; $display("FAIL rst_ready_lsb: got %b want 0", l_ready); end
        tests_run++; if (def_sout !== 1'b0) begin fails++; $display("FAIL rst_sout_def: got %b want 0", def_sout); end
        tests_run++; if (l_sout !== 1'b1) begin fails++; $display("FAIL rst_sout_lsb: got %b want 1", l_sout); end
        tests_run++; if (def_level !== 3'd0) begin fails++; $display("FAIL rst_level_def: got %0d want 0", def_level); end
        tests_run++; if (l_level !== 3'd0) begin fails++; $display("FAIL rst_level_lsb: got %0d want 0", l_level); end
        tests_run++; if (def_busy !== 1'b0) begin fails++; $display("FAIL rst_busy_def: got %b want 0", def_busy); end
        tests_run++; if (l_busy !== 1'b0) begin fails++; $display("FAIL rst_busy_lsb: got %b want 0", l_busy); end
        tests_run++; if (def_done !== 1'b0) begin fails++; $display("FAIL rst_done_def: got %b want 0", def_done); end
        def_reset = 1'b0;
        b_reset = 1'b0;
        l_reset = 1'b0;
        @(negedge clk);
        tests_run++; if (def_ready !== 1'b1) begin fails++; $display("FAIL rel_ready_def: got %b want 1", def_ready); end
        tests_run++; if (b_ready !== 1'b1) begin fails++; $display("FAIL rel_ready_b2b: got %b want 1", b_ready); end
        tests_run++; if (l_ready !== 1'b1) begin fails++; $display("FAIL rel_ready_lsb: got %b want 1", l_ready); end
    endtask

    // 40'h80_0000_0001, tick every 4 cycles: 1,1,0x38,1 then gap 0, done on tick 41
    task automatic test_default_frame();
        logic e;
        @(negedge clk);
        def_data = 40'h80_0000_0001;
        def_valid = 1'b1;
        @(negedge clk);
        def_valid = 1'b0;
        for (int k = 0; k < 43; k++) begin
            def_tick = 1'b1;
            @(negedge clk);
            def_tick = 1'b0;
            e = (k == 0 || k == 1 || k == 40) ? 1'b1 : 1'b0;
            tests_run++; if (def_sout !== e) begin fails++; $display("FAIL def_sout tick %0d: got %b want %b", k, def_sout, e); end
            tests_run++; if (def_done !== (k == 41)) begin fails++; $display("FAIL def_done tick %0d: got %b want %b", k, def_done, (k == 41)); end
            if (k == 41) begin
                tests_run++; if (def_busy !== 1'b1) begin fails++; $display("FAIL def_busy_gap: got %b want 1", def_busy); end
            end
            if (k == 42) begin
                tests_run++; if (def_busy !== 1'b0) begin fails++; $display("FAIL def_busy_after: got %b want 0", def_busy); end
            end
            repeat (3) @(negedge clk);
            tests_run++; if (def_sout !== e) begin fails++; $display("FAIL def_hold tick %0d: got %b want %b", k, def_sout, e); end
        end
    endtask

    // A5 then 3C with bit_tick stuck high and no gap
    task automatic test_back_to_back();
        logic [18:0] exp_bits;
        exp_bits = 19'b1_10100101_1_00111100_0;
        @(negedge clk);
        b_tick = 1'b1;
        b_valid = 1'b1;
        b_data = 8'hA5;
        @(negedge clk);
        b_data = 8'h3C;
        @(negedge clk);
        b_valid = 1'b0;
        tests_run++; if (b_level !== 3'd1) begin fails++; $display("FAIL b2b_level_pushpop: got %0d want 1", b_level); end
        for (int i = 0; i < 19; i++) begin
            if (i > 0) @(negedge clk);
            tests_run++; if (b_sout !== exp_bits[18-i]) begin fails++; $display("FAIL b2b_sout bit %0d: got %b want %b", i, b_sout, exp_bits[18-i]); end
            tests_run++; if (b_done !== (i == 9 || i == 18)) begin fails++; $display("FAIL b2b_done bit %0d: got %b want %b", i, b_done, (i == 9 || i == 18)); end
        end
        tests_run++; if (b_busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_end: got %b want 0", b_busy); end
        b_tick = 1'b0;
    endtask

    // Fill to full with tick low, then one tick frees a slot; drain and check order
    task automatic test_fifo_full();
        logic [7:0]  words [5];
        logic [45:0] exp_all;
        logic        acc;
        int          idx;
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        exp_all = {1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 8'h33, 1'b1, 8'h44, 1'b1, 8'h55, 1'b0};
        @(negedge clk);
        b_tick = 1'b0;
        b_valid = 1'b1;
        idx = 0;
        b_data = words[0];
        for (int c = 0; c < 6; c++) begin
            acc = b_ready;
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 5) b_data = words[idx];
            end
        end
        tests_run++; if (idx !== 4) begin fails++; $display("FAIL fifo_accepted: got %0d want 4", idx); end
        tests_run++; if (b_level !== 3'd4) begin fails++; $display("FAIL fifo_level_full: got %0d want 4", b_level); end
        tests_run++; if (b_ready !== 1'b0) begin fails++; $display("FAIL fifo_ready_full: got %b want 0", b_ready); end
        b_tick = 1'b1;
        @(negedge clk);
        b_tick = 1'b0;
        tests_run++; if (b_level !== 3'd3) begin fails++; $display("FAIL fifo_level_pop: got %0d want 3", b_level); end
        tests_run++; if (b_ready !== 1'b1) begin fails++; $display("FAIL fifo_ready_pop: got %b want 1", b_ready); end
        tests_run++; if (b_sout !== 1'b1) begin fails++; $display("FAIL fifo_start: got %b want 1", b_sout); end
        @(negedge clk);
        b_valid = 1'b0;
        tests_run++; if (b_level !== 3'd4) begin fails++; $display("FAIL fifo_level_refill: got %0d want 4", b_level); end
        b_tick = 1'b1;
        for (int i = 1; i < 46; i++) begin
            @(negedge clk);
            tests_run++; if (b_sout !== exp_all[45-i]) begin fails++; $display("FAIL fifo_drain bit %0d: got %b want %b", i, b_sout, exp_all[45-i]); end
        end
        b_tick = 1'b0;
        tests_run++; if (b_busy !== 1'b0) begin fails++; $display("FAIL fifo_busy_end: got %b want 0", b_busy); end
        tests_run++; if (b_level !== 3'd0) begin fails++; $display("FAIL fifo_level_end: got %0d want 0", b_level); end
    endtask

    // LSB first, idle-high: 8'h01 -> 1,1,0x7 then line stays 1
    task automatic test_lsb_idle_high();
        logic [10:0] exp_bits;
        exp_bits = 11'b11_0000000_11;
        @(negedge clk);
        l_data = 8'h01;
        l_valid = 1'b1;
        @(negedge clk);
        l_valid = 1'b0;
        for (int k = 0; k < 11; k++) begin
            l_tick = 1'b1;
            @(negedge clk);
            l_tick = 1'b0;
            tests_run++; if (l_sout !== exp_bits[10-k]) begin fails++; $display("FAIL lsb_sout tick %0d: got %b want %b", k, l_sout, exp_bits[10-k]); end
            tests_run++; if (l_done !== (k == 9)) begin fails++; $display("FAIL lsb_done tick %0d: got %b want %b", k, l_done, (k == 9)); end
            @(negedge clk);
        end
        tests_run++; if (l_busy !== 1'b0) begin fails++; $display("FAIL lsb_busy_end: got %b want 0", l_busy); end
        tests_run++; if (l_sout !== 1'b1) begin fails++; $display("FAIL lsb_idle_level: got %b want 1", l_sout); end
    endtask

    // Reset asserted after the 5th data bit with two words still queued
    task automatic test_reset_midframe();
        @(negedge clk);
        def_valid = 1'b1;
        def_data = 40'hF8_0000_0000;
        @(negedge clk);
        def_data = 40'h12_3456_789A;
        @(negedge clk);
        def_data = 40'hFF_FFFF_FFFF;
        @(negedge clk);
        def_valid = 1'b0;
        tests_run++; if (def_level !== 3'd3) begin fails++; $display("FAIL mid_level_fill: got %0d want 3", def_level); end
        for (int k = 0; k < 6; k++) begin
            def_tick = 1'b1;
            @(negedge clk);
            def_tick = 1'b0;
            @(negedge clk);
        end
        tests_run++; if (def_sout !== 1'b1) begin fails++; $display("FAIL mid_sout_before: got %b want 1", def_sout); end
        tests_run++; if (def_level !== 3'd2) begin fails++; $display("FAIL mid_level_before: got %0d want 2", def_level); end
        def_reset = 1'b1;
        def_tick = 1'b1;
        #1;
        tests_run++; if (def_ready !== 1'b0) begin fails++; $display("FAIL mid_ready_in_reset: got %b want 0", def_ready); end
        @(negedge clk);
        tests_run++; if (def_sout !== 1'b0) begin fails++; $display("FAIL mid_sout_reset: got %b want 0", def_sout); end
        tests_run++; if (def_level !== 3'd0) begin fails++; $display("FAIL mid_level_reset: got %0d want 0", def_level); end
        tests_run++; if (def_busy !== 1'b0) begin fails++; $display("FAIL mid_busy_reset: got %b want 0", def_busy); end
        tests_run++; if (def_done !== 1'b0) begin fails++; $display("FAIL mid_done_reset: got %b want 0", def_done); end
        tests_run++; if (def_ready !== 1'b0) begin fails++; $display("FAIL mid_ready_reset2: got %b want 0", def_ready); end
        @(negedge clk);
        def_reset = 1'b0;
        def_tick = 1'b0;
        @(negedge clk);
        tests_run++; if (def_ready !== 1'b1) begin fails++; $display("FAIL mid_ready_release: got %b want 1", def_ready); end
        tests_run++; if (def_busy !== 1'b0) begin fails++; $display("FAIL mid_busy_release: got %b want 0", def_busy); end
        tests_run++; if (def_sout !== 1'b0) begin fails++; $display("FAIL mid_sout_release: got %b want 0", def_sout); end
        tests_run++; if (def_done !== 1'b0) begin fails++; $display("FAIL mid_done_release: got %b want 0", def_done); end
    endtask

    // 100-cycle tick stall after the 3rd data bit of 40'hAA_AAAA_AAAA
    task automatic test_stall();
        logic e;
        int   stall_bad;
        @(negedge clk);
        def_data = 40'hAA_AAAA_AAAA;
        def_valid = 1'b1;
        @(negedge clk);
        def_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            def_tick = 1'b1;
            @(negedge clk);
            def_tick = 1'b0;
            @(negedge clk);
        end
        tests_run++; if (def_sout !== 1'b1) begin fails++; $display("FAIL stall_sout_before: got %b want 1", def_sout); end
        stall_bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (def_sout !== 1'b1 || def_done !== 1'b0) stall_bad++;
        end
        tests_run++; if (stall_bad !== 0) begin fails++; $display("FAIL stall_hold: got %0d bad cycles want 0", stall_bad); end
        for (int k = 4; k < 43; k++) begin
            def_tick = 1'b1;
            @(negedge clk);
            def_tick = 1'b0;
            e = (k <= 40 && (k % 2) == 1) ? 1'b1 : 1'b0;
            tests_run++; if (def_sout !== e) begin fails++; $display("FAIL stall_sout tick %0d: got %b want %b", k, def_sout, e); end
            tests_run++; if (def_done !== (k == 41)) begin fails++; $display("FAIL stall_done tick %0d: got %b want %b", k, def_done, (k == 41)); end
            @(negedge clk);
        end
        tests_run++; if (def_busy !== 1'b0) begin fails++; $display("FAIL stall_busy_end: got %b want 0", def_busy); end
    endtask

    initial begin
        test_reset();
        test_default_frame();
        test_back_to_back();
        test_fifo_full();
        test_lsb_idle_high();
        test_reset_midframe();
        test_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
